// File: rtl/rx_sample_scaler_ctrl.sv
// ---------------------------------------------------------------------------
// rx_sample_scaler_ctrl
//
// Converts wide signed receive samples to OUT_W-bit signed samples at the end
// of the decimation chain: round-half-up after an arithmetic right shift by
// the current shift value, then saturate. Two-stage pipeline that stalls as a
// whole whenever the output register holds data downstream has not taken.
//
// Optional feature macro: RX_SCALER_AGC_EN
//   Defined     : gain scheduler (MEASURE/ADJUST) nudges the shift once per
//                 2^WIN_LOG2 output handshakes from clip and peak statistics.
//   Not defined : the shift changes only through shift_load_i.
//
// Ports
//   clk_i         clock, all logic on rising edge
//   rst_i         synchronous reset, active-high
//   data_i        IN_W signed input sample
//   valid_i       data_i valid
//   ready_o       block accepts data_i this cycle
//   data_o        OUT_W signed rounded, saturated sample
//   valid_o       data_o valid
//   ready_i       downstream accepts data_o
//   shift_set_i   software shift value
//   shift_load_i  one-cycle strobe: load shift_set_i (clamped)
//   shift_o       shift applied to newly accepted samples
//   clip_o        pulse when a saturated sample is transferred out
// ---------------------------------------------------------------------------
module rx_sample_scaler_ctrl #(
    parameter int IN_W      = 53,
    parameter int OUT_W     = 16,
    parameter int SHIFT_DEF = 38,
    parameter int SHIFT_MIN = 30,
    parameter int SHIFT_MAX = 44,
    parameter int WIN_LOG2  = 10
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [IN_W-1:0]  data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [OUT_W-1:0] data_o,
    output logic             valid_o,
    input  logic             ready_i,
    input  logic [5:0]       shift_set_i,
    input  logic             shift_load_i,
    output logic [5:0]       shift_o,
    output logic             clip_o
);

    localparam int SUM_W = IN_W + 1;
    localparam logic [5:0] C_SDEF = 6'(SHIFT_DEF);
    localparam logic [5:0] C_SMIN = 6'(SHIFT_MIN);
    localparam logic [5:0] C_SMAX = 6'(SHIFT_MAX);
    localparam logic signed [SUM_W-1:0] SAT_MAX = (SUM_W'(1) << (OUT_W - 1)) - SUM_W'(1);
    // two's complement: ~max == -max-1 == most negative output value
    localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

    logic [5:0]              r_shift;
    logic                    r_v1;
    logic signed [SUM_W-1:0] r_sum1;
    logic [5:0]              r_s1;
    logic                    r_v2;
    logic [OUT_W-1:0]        r_data;
    logic                    r_clip2;

    logic                    w_adv;
    logic                    w_acc;
    logic signed [SUM_W-1:0] w_half;
    logic signed [SUM_W-1:0] w_sum1;
    logic signed [SUM_W-1:0] w_shr;
    logic [OUT_W-1:0]        w_sat;
    logic                    w_clip;
    logic [5:0]              w_load_val;

    // The output register either is empty or is being drained: everything moves.
    assign w_adv   = !r_v2 || ready_i;
    assign ready_o = !rst_i && w_adv;
    assign w_acc   = valid_i && ready_o;

    // Stage 1 adder: one extra bit so the rounding offset can never overflow.
    assign w_half = SUM_W'(1) << (r_shift - 6'd1);
    assign w_sum1 = $signed({data_i[IN_W-1], data_i}) + w_half;

    // Stage 2: floor shift of (x + half) gives round-half-up.
    assign w_shr = r_sum1 >>> r_s1;

    always_comb begin
        w_sat  = w_shr[OUT_W-1:0];
        w_clip = 1'b0;
        if (w_shr > SAT_MAX) begin
            w_sat  = SAT_MAX[OUT_W-1:0];
            w_clip = 1'b1;
        end else if (w_shr < SAT_MIN) begin
            w_sat  = SAT_MIN[OUT_W-1:0];
            w_clip = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_v1    <= 1'b0;
            r_sum1  <= '0;
            r_s1    <= C_SDEF;
            r_v2    <= 1'b0;
            r_data  <= '0;
            r_clip2 <= 1'b0;
        end else if (w_adv) begin
            r_v1 <= w_acc;
            if (w_acc) begin
                r_sum1 <= w_sum1;
                r_s1   <= r_shift;   // each sample keeps the shift it was accepted with
            end
            r_v2 <= r_v1;
            if (r_v1) begin
                r_data  <= w_sat;
                r_clip2 <= w_clip;
            end
        end
    end

    assign data_o  = r_data;
    assign valid_o = r_v2;
    assign clip_o  = !rst_i && r_v2 && ready_i && r_clip2;
    assign shift_o = r_shift;

    always_comb begin
        w_load_val = shift_set_i;
        if (shift_set_i < C_SMIN)
            w_load_val = C_SMIN;
        else if (shift_set_i > C_SMAX)
            w_load_val = C_SMAX;
    end

`ifdef RX_SCALER_AGC_EN
    typedef enum logic {S_MEASURE, S_ADJUST} state_t;

    localparam logic [OUT_W:0] PEAK_LOW = (OUT_W+1)'(1) << (OUT_W - 3);

    state_t              r_state;
    logic [WIN_LOG2-1:0] r_win_cnt;
    logic                r_clip_seen;
    logic [OUT_W:0]      r_peak;
    logic                w_hs;
    logic [OUT_W:0]      w_abs;

    assign w_hs  = r_v2 && ready_i;
    // one extra bit so |-2^(OUT_W-1)| is representable
    assign w_abs = r_data[OUT_W-1] ? ({1'b0, ~r_data} + (OUT_W+1)'(1)) : {1'b0, r_data};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_MEASURE;
            r_win_cnt   <= '0;
            r_clip_seen <= 1'b0;
            r_peak      <= '0;
            r_shift     <= C_SDEF;
        end else if (shift_load_i) begin
            // software load wins over a pending adjustment and restarts the window
            r_shift     <= w_load_val;
            r_state     <= S_MEASURE;
            r_win_cnt   <= '0;
            r_clip_seen <= 1'b0;
            r_peak      <= '0;
        end else begin
            case (r_state)
                S_MEASURE: begin
                    if (w_hs) begin
                        r_win_cnt <= r_win_cnt + 1'b1;
                        if (r_clip2)
                            r_clip_seen <= 1'b1;
                        if (w_abs > r_peak)
                            r_peak <= w_abs;
                        if (&r_win_cnt)
                            r_state <= S_ADJUST;
                    end
                end
                S_ADJUST: begin
                    if (r_clip_seen) begin
                        if (r_shift < C_SMAX)
                            r_shift <= r_shift + 6'd1;
                    end else if (r_peak < PEAK_LOW) begin
                        if (r_shift > C_SMIN)
                            r_shift <= r_shift - 6'd1;
                    end
                    // a handshake this cycle opens the next window
                    r_win_cnt   <= r_win_cnt + WIN_LOG2'(w_hs);
                    r_clip_seen <= w_hs && r_clip2;
                    r_peak      <= w_hs ? w_abs : '0;
                    r_state     <= S_MEASURE;
                end
                default: r_state <= S_MEASURE;
            endcase
        end
    end
`else
    // window size only matters to the gain scheduler
    logic [WIN_LOG2-1:0] w_unused_win;
    assign w_unused_win = '0;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_shift <= C_SDEF;
        else if (shift_load_i)
            r_shift <= w_load_val;
    end
`endif

endmodule
